// File: rtl/alarm_ring_sequencer.sv
// Alarm ring sequencer: arms on a stored alarm, rings on a time match, and handles
// dismiss / snooze / ring timeout. Snooze support is compiled in with `define SNOOZE_EN.
module alarm_ring_sequencer #(
    parameter int TW           = 7,
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 5,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          tick,
    input  logic [TW-1:0] cur_time,
    input  logic [TW-1:0] alarm_time,
    input  logic          alarm_isset,
    input  logic          dismiss,
    input  logic          snooze,
    output logic          ring,
    output logic          alarm_clear,
    output logic          missed,
    output logic [1:0]    snooze_left,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam int RCW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;
    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_TICKS - 1);

    state_t         state_q, state_d;
    logic           ring_q, ring_d;
    logic           clear_q, clear_d;
    logic           missed_q, missed_d;
    logic [RCW-1:0] ring_cnt_q, ring_cnt_d;

    logic time_match;
    logic ring_done;
    logic snooze_go;
    logic snz_done;

    assign time_match = tick && (cur_time == alarm_time);
    assign ring_done  = tick && (ring_cnt_q == RING_LAST);

`ifdef SNOOZE_EN
    localparam int SCW = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
    localparam logic [SCW-1:0] SNZ_LAST = SCW'(SNOOZE_TICKS - 1);
    // snooze_left is only 2 bits wide, so larger allowances saturate at 3.
    localparam logic [1:0] SNZ_INIT = (MAX_SNOOZE > 3) ? 2'd3 : 2'(MAX_SNOOZE);

    logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]     snz_left_q, snz_left_d;

    assign snooze_go = snooze && (snz_left_q != 2'd0);
    assign snz_done  = tick && (snz_cnt_q == SNZ_LAST);

    // Snooze bookkeeping follows the main FSM's decision rather than re-deriving it.
    always_comb begin
        snz_cnt_d  = snz_cnt_q;
        snz_left_d = snz_left_q;
        if (state_q == ARMED && state_d == RINGING) begin
            snz_left_d = SNZ_INIT;
        end else if (state_q == RINGING && state_d == SNOOZE) begin
            snz_left_d = snz_left_q - 2'd1;
            snz_cnt_d  = '0;
        end else if (state_q == SNOOZE && state_d == SNOOZE && tick) begin
            snz_cnt_d  = snz_cnt_q + SCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            snz_cnt_q  <= '0;
            snz_left_q <= SNZ_INIT;
        end else begin
            snz_cnt_q  <= snz_cnt_d;
            snz_left_q <= snz_left_d;
        end
    end

    assign snooze_left = snz_left_q;
`else
    logic snooze_unused;
    localparam int snz_params_unused = SNOOZE_TICKS + MAX_SNOOZE;

    assign snooze_unused = snooze;
    assign snooze_go     = 1'b0;
    assign snz_done      = 1'b0;
    assign snooze_left   = 2'd0;
`endif

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        clear_d    = 1'b0;
        missed_d   = missed_q;
        ring_cnt_d = ring_cnt_q;

        if (!alarm_isset) begin
            // Alarm withdrawn externally: the store already knows, so no clear pulse.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (time_match) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        missed_d   = 1'b0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d  = IDLE;
                        clear_d  = 1'b1;
                        missed_d = 1'b0;
                    end else if (ring_done) begin
                        state_d  = IDLE;
                        clear_d  = 1'b1;
                        missed_d = 1'b1;
                    end else if (snooze_go) begin
                        state_d = SNOOZE;
                    end else if (tick) begin
                        ring_cnt_d = ring_cnt_q + RCW'(1);
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_d  = IDLE;
                        clear_d  = 1'b1;
                        missed_d = 1'b0;
                    end else if (snz_done) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered from the next state so ring lines up exactly with state==RINGING.
        ring_d = (state_d == RINGING);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_q     <= 1'b0;
            clear_q    <= 1'b0;
            missed_q   <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            clear_q    <= clear_d;
            missed_q   <= missed_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign ring        = ring_q;
    assign alarm_clear = clear_q;
    assign missed      = missed_q;
    assign state       = state_q;

endmodule
